clk_fwd_diff_out_multi: RTL and testbench

- Multi-channel forwarded-clock generator for MOPSHUB debug and bus-side outputs.
- Derives N_CH independently divided, glitch-free, 50%-duty clocks from one system clock.
- Gates all channels on a synchronised, debounced PLL lock.
- Drives each channel through an OBUFDS differential output pair, with per-channel polarity swap for board P/N crossings.

---
 rtl/clk_fwd_diff_out_multi_pkg.sv | 17 +
 rtl/OBUFDS.sv | 12 +
 rtl/clk_div_channel.sv | 110 +++++++++++
 rtl/clk_fwd_diff_out_multi.sv | 81 ++++++++
 tb/tb_clk_fwd_diff_out_multi.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/clk_fwd_diff_out_multi_pkg.sv
// Shared definitions for the forwarded-clock generator:
// channel FSM states, lock debounce default, half-period slice.
`ifndef CLK_FWD_HP_SLICE
`define CLK_FWD_HP_SLICE(i, w) (i)*(w) +: (w)
`endif

package clk_fwd_diff_out_multi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } ch_state_t;

   localparam int LOCK_WAIT_DEF = 64;

endpackage

// File: rtl/OBUFDS.sv
// Behavioural stand-in for the vendor differential output buffer.
// Ports: I single-ended in, O true output, OB complement output.
module OBUFDS (
   input  logic I,
   output logic O,
   output logic OB
);

   assign O  = I;
   assign OB = ~I;

endmodule

// File: rtl/clk_div_channel.sv
// One forwarded-clock channel: divider FSM, counter, half-period regs.
// Ports: clk, rst (async high), run, half_period, clk_o, active.
module clk_div_channel
   import clk_fwd_diff_out_multi_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [DIV_W-1:0] half_period,
   output logic             clk_o,
   output logic             active
);

   ch_state_t        state, state_d;
   logic [DIV_W-1:0] cnt, cnt_d;
   logic [DIV_W-1:0] hp, hp_d;
   logic [DIV_W-1:0] hp_nxt, hp_nxt_d;
   logic             clk_d, active_d;
   logic [DIV_W-1:0] hp_in;
   logic             term;

   // A zero half-period would never reach its terminal count.
   assign hp_in = (half_period == '0) ? DIV_W'(1) : half_period;
   assign term  = (cnt == hp - DIV_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         hp     <= DIV_W'(1);
         hp_nxt <= DIV_W'(1);
         clk_o  <= 1'b0;
         active <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         hp     <= hp_d;
         hp_nxt <= hp_nxt_d;
         clk_o  <= clk_d;
         active <= active_d;
      end
   end

   // The ratio is sampled at each falling edge into hp_nxt and
   // applied at the next rising edge, so every period stays 50%.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      hp_d     = hp;
      hp_nxt_d = hp_nxt;
      clk_d    = clk_o;
      active_d = active;
      unique case (state)
         IDLE: begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (run) begin
               state_d  = RUN;
               hp_d     = hp_in;
               hp_nxt_d = hp_in;
               active_d = 1'b1;
            end
         end
         RUN: begin
            if (!run && !clk_o) begin
               state_d  = IDLE;
               cnt_d    = '0;
               active_d = 1'b0;
            end else if (term) begin
               cnt_d = '0;
               clk_d = ~clk_o;
               if (clk_o) begin
                  hp_nxt_d = hp_in;
               end else begin
                  hp_d = hp_nxt;
               end
               // Only reachable with clk_o high: this is the fall.
               if (!run) begin
                  state_d  = IDLE;
                  active_d = 1'b0;
               end
            end else begin
               cnt_d = cnt + DIV_W'(1);
               if (!run) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (term) begin
               cnt_d    = '0;
               clk_d    = 1'b0;
               state_d  = IDLE;
               active_d = 1'b0;
            end else begin
               cnt_d = cnt + DIV_W'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            clk_d    = 1'b0;
            active_d = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/clk_fwd_diff_out_multi.sv
// Multi-channel forwarded clock generator with lock debounce.
// Ports: clk, rst, locked, ch_en, half_period, ready, ch_active,
// clk_out_p, clk_out_n (differential pads per channel).
module clk_fwd_diff_out_multi
   import clk_fwd_diff_out_multi_pkg::*;
#(
   parameter int              N_CH      = 4,
   parameter int              DIV_W     = 8,
   parameter int              LOCK_WAIT = LOCK_WAIT_DEF,
   parameter logic [N_CH-1:0] POL_INV   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  locked,
   input  logic [N_CH-1:0]       ch_en,
   input  logic [N_CH*DIV_W-1:0] half_period,
   output logic                  ready,
   output logic [N_CH-1:0]       ch_active,
   output logic [N_CH-1:0]       clk_out_p,
   output logic [N_CH-1:0]       clk_out_n
);

   localparam int LK_W =
      (LOCK_WAIT < 1) ? 1 : $clog2(LOCK_WAIT + 1);
   localparam logic [LK_W-1:0] LK_END = LK_W'(LOCK_WAIT);

   logic            lock_m, lock_s;
   logic [LK_W-1:0] lk_cnt;
   logic [N_CH-1:0] run;
   logic [N_CH-1:0] ch_clk;
   logic [N_CH-1:0] pad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= locked;
         lock_s <= lock_m;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_cnt <= '0;
         ready  <= 1'b0;
      end else begin
         if (!lock_s) begin
            lk_cnt <= '0;
         end else if (lk_cnt != LK_END) begin
            lk_cnt <= lk_cnt + LK_W'(1);
         end
         ready <= lock_s && (lk_cnt == LK_END);
      end
   end

   assign run = {N_CH{ready}} & ch_en;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      clk_div_channel #(
         .DIV_W (DIV_W)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .run         (run[g]),
         .half_period (half_period[`CLK_FWD_HP_SLICE(g, DIV_W)]),
         .clk_o       (ch_clk[g]),
         .active      (ch_active[g])
      );

      // Constant XOR only: the pad stays a direct flop copy.
      assign pad[g] = ch_clk[g] ^ POL_INV[g];

      OBUFDS u_obuf (
         .I  (pad[g]),
         .O  (clk_out_p[g]),
         .OB (clk_out_n[g])
      );
   end

endmodule

// File: tb/tb_clk_fwd_diff_out_multi.sv
// Bench for clk_fwd_diff_out_multi: edge-time scoreboard per channel.
module tb_clk_fwd_diff_out_multi;

   localparam logic [3:0] POL = 4'b0010;

   logic        clk = 1'b0;
   logic        rst;
   logic        locked;
   logic [3:0]  ch_en;
   logic [31:0] half_period;
   logic        ready;
   logic [3:0]  ch_active;
   logic [3:0]  clk_out_p;
   logic [3:0]  clk_out_n;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int q [4][$];
   bit quiet [4];
   logic [3:0] prev = '0;
   logic       mcur;

   clk_fwd_diff_out_multi #(
      .N_CH      (4),
      .DIV_W     (8),
      .LOCK_WAIT (64),
      .POL_INV   (POL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .locked      (locked),
      .ch_en       (ch_en),
      .half_period (half_period),
      .ready       (ready),
      .ch_active   (ch_active),
      .clk_out_p   (clk_out_p),
      .clk_out_n   (clk_out_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s obs=%0d exp=%0d cyc=%0d",
                    tag, obs, exp, cyc);
   endtask

   task automatic go(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Expected edges of a free-running channel: every h cycles from e.
   task automatic push_run(input int c, input int e,
                           input int h, input int n);
      for (int k = 1; k <= n; k++)
         q[c].push_back((e + k * h) * 2 + (k % 2));
   endtask

   task automatic wait_idle();
      int n = 0;
      while (ch_active != 4'b0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("idle", ch_active, 0);
   endtask

   task automatic chk_empty(input string tag);
      for (int c = 0; c < 4; c++) chk(tag, q[c].size(), 0);
   endtask

   // Monitor: normalise pad polarity, compare each edge to the queue.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < 4; c++) begin
            mcur = clk_out_p[c] ^ POL[c];
            if (mcur != prev[c]) begin
               chk("pn", clk_out_n[c], !clk_out_p[c]);
               if (q[c].size() != 0)
                  chk($sformatf("edge%0d", c),
                      cyc * 2 + int'(mcur), q[c].pop_front());
               else if (quiet[c])
                  chk($sformatf("spur%0d", c), mcur, prev[c]);
            end
            prev[c] <= mcur;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      int c0, e, l;
      rst = 1'b1;
      locked = 1'b0;
      ch_en = 4'h0;
      half_period = 32'h02020202;
      for (int c = 0; c < 4; c++) quiet[c] = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_act", ch_active, 0);
      chk("rst_p", clk_out_p, 4'b0010);
      chk("rst_n", clk_out_n, 4'b1101);

      // Lock debounce and hp=2 on all channels.
      rst = 1'b0;
      c0 = cyc;
      locked = 1'b1;
      ch_en = 4'hf;
      e = c0 + 68;
      for (int c = 0; c < 4; c++) push_run(c, e, 2, 6);
      go(c0 + 66);
      chk("ready_early", ready, 0);
      go(c0 + 67);
      chk("ready_rise", ready, 1);
      chk("act_pre", ch_active, 0);
      go(c0 + 68);
      chk("act_on", ch_active, 4'hf);
      go(e + 13);
      chk_empty("q_a");
      ch_en = 4'h0;
      wait_idle();

      // Mixed ratios; hp=0 must behave as hp=1.
      half_period = {8'd255, 8'd0, 8'd3, 8'd1};
      ch_en = 4'hf;
      e = cyc + 1;
      push_run(0, e, 1, 8);
      push_run(1, e, 3, 6);
      push_run(2, e, 1, 8);
      push_run(3, e, 255, 3);
      go(e + 766);
      chk_empty("q_b");
      ch_en = 4'h0;
      wait_idle();

      // Ratio change during the high phase of ch1.
      ch_en = 4'b0010;
      e = cyc + 1;
      q[1].push_back((e + 3) * 2 + 1);
      q[1].push_back((e + 6) * 2);
      q[1].push_back((e + 9) * 2 + 1);
      q[1].push_back((e + 14) * 2);
      q[1].push_back((e + 19) * 2 + 1);
      q[1].push_back((e + 24) * 2);
      go(e + 4);
      half_period[15:8] = 8'd5;
      go(e + 25);
      chk_empty("q_c");
      ch_en = 4'h0;
      wait_idle();

      // Enable drop just after a rising edge: full high, then silent.
      half_period[7:0] = 8'd4;
      ch_en = 4'b0001;
      e = cyc + 1;
      q[0].push_back((e + 4) * 2 + 1);
      q[0].push_back((e + 8) * 2);
      quiet[0] = 1'b1;
      go(e + 5);
      ch_en = 4'b0000;
      go(e + 7);
      chk("stop_act", ch_active[0], 1);
      chk("idle_p1", clk_out_p[1], 1);
      go(e + 8);
      chk("stop_done", ch_active[0], 0);
      go(e + 30);
      chk_empty("q_d");
      quiet[0] = 1'b0;

      // One-cycle lock glitch while running at hp=2.
      half_period = 32'h02020202;
      ch_en = 4'hf;
      e = cyc + 1;
      l = e + 7;
      for (int c = 0; c < 4; c++) begin
         push_run(c, e, 2, 6);
         push_run(c, e + 76, 2, 4);
         quiet[c] = 1'b1;
      end
      go(l);
      locked = 1'b0;
      go(l + 1);
      locked = 1'b1;
      go(l + 2);
      chk("glitch_hold", ready, 1);
      go(l + 3);
      chk("glitch_drop", ready, 0);
      go(l + 30);
      chk("gap_act", ch_active, 0);
      chk("gap_p", clk_out_p, 4'b0010);
      go(l + 67);
      chk("relock_early", ready, 0);
      go(l + 68);
      chk("relock", ready, 1);
      go(e + 85);
      for (int c = 0; c < 4; c++) quiet[c] = 1'b0;
      ch_en = 4'h0;
      chk_empty("q_e");
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
